mem_pipe: RTL
=============

# mem_pipe

Parametrised single-port synchronous memory with a valid/ready request interface, configurable read latency and a buffered, back-pressurable read-response path. It is the next-generation data memory for the VeriRISC core and its benches: it replaces the bare read/write strobe memory where the consumer cannot always take read data on a fixed cycle. Reads return in order; writes complete silently.

## Interface

- ADDR_WIDTH, 5, address bits; memory depth is 2**ADDR_WIDTH words
- DATA_WIDTH, 8, word width in bits
- READ_LATENCY, 1, cycles from read acceptance to earliest resp_valid; legal range 1..4
- RESP_DEPTH, 4, response buffer depth and maximum outstanding reads; must be >= READ_LATENCY

- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  request can be accepted this cycle
- req_write  input  1  1 = write, 0 = read
- req_addr  input  ADDR_WIDTH  word address
- req_wdata  input  DATA_WIDTH  write data, ignored for reads
- resp_valid  output  1  read data present at head of response buffer
- resp_ready  input  1  consumer takes the head response this cycle
- resp_rdata  output  DATA_WIDTH  read data; valid only while resp_valid
- outstanding  output  $clog2(RESP_DEPTH+1)  reads in flight plus reads buffered

## Operation

- Accept: a request is accepted on an edge where req_valid && req_ready; at most one request per cycle.
- Write: mem[req_addr] <= req_wdata on the accepting edge. No response; outstanding unchanged.
- Read: mem[req_addr] is sampled on the accepting edge, carried through a READ_LATENCY-stage pipeline, then written into the response FIFO. outstanding increments on acceptance.
- Ordering: read data reflects every write accepted on an earlier edge. Responses leave in acceptance order.
- Pop: an edge with resp_valid && resp_ready removes the head entry and decrements outstanding.
- Accept and pop on the same edge leave outstanding unchanged.
- Flow control: req_ready = !rst && (outstanding < RESP_DEPTH), decoded from the registered count only. A pop on the current edge does not raise req_ready in the same cycle.
- Writes are also gated by req_ready, so one rule covers all requests.
- Array: no initial value; never cleared by rst.
- Status: resp_valid = FIFO not empty; resp_rdata = FIFO head. With resp_valid low, resp_rdata holds its last value.

## Timing

- Reset values (rst high at an edge): pipeline valid bits 0, FIFO empty, outstanding 0, resp_valid 0, resp_rdata 0.
- req_ready is 0 for every cycle that rst is high.
- Reset mid-operation: in-flight and buffered reads are discarded and never returned. Memory contents are preserved. No request is accepted in the reset cycle.
- Read latency: a read accepted on edge E with an empty FIFO gives resp_valid = 1 in the cycle after edge E+READ_LATENCY-1, i.e. resp_valid high READ_LATENCY cycles after the request cycle.
- Back-to-back reads: one per cycle at full throughput while resp_ready stays high.
- Full: when outstanding = RESP_DEPTH, req_ready drops. It rises in the cycle after the first pop.
- FIFO overflow cannot occur: RESP_DEPTH >= READ_LATENCY and credits are counted at acceptance.
- Address wrap: req_addr uses all ADDR_WIDTH bits, so there are no out-of-range addresses.
- Write then read, same address, consecutive cycles: the read returns the new data.

## Test plan

- Reset check: rst high for 2 cycles -> req_ready=0, resp_valid=0, outstanding=0. After rst falls -> req_ready=1.
- Latency sweep: write 8'hA5 to addr 3, then read addr 3 with READ_LATENCY=1 and again with READ_LATENCY=3, resp_ready=1 -> resp_rdata=8'hA5 exactly 1 and 3 cycles after the read cycle.
- Streaming reads: fill addr 0..31 with data = addr^8'h5A, then issue 32 back-to-back reads with resp_ready=1 -> 32 in-order responses, one per cycle, req_ready never drops.
- Back-pressure: RESP_DEPTH=4, resp_ready=0, issue 6 reads:
  - 4 are accepted, req_ready=0 from then on, outstanding=4.
  - Raise resp_ready for one cycle -> one pop; req_ready=1 the next cycle; the 5th read is accepted.
- Write/read hazard: same-cycle accept+pop holds outstanding at 2. A write of 8'h3C to addr 7 followed immediately by a read of addr 7 returns 8'h3C.
- Reset mid-flight: 3 reads outstanding, assert rst for 1 cycle -> no responses ever appear, outstanding=0, and a later read of a previously written address returns the pre-reset data.

Source files
------------

// File: rtl/mem_pipe_if.sv
// mem_pipe_if: request/response bus between a memory client and mem_pipe
interface mem_pipe_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int RESP_DEPTH = 4
);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic resp_valid;
  logic resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic [CW-1:0] outstanding;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, outstanding
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, outstanding
  );
endinterface

// File: rtl/mem_pipe.sv
// mem_pipe: single-port memory with latency pipeline and back-pressurable in-order read responses
module mem_pipe #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int READ_LATENCY = 1,
  parameter int RESP_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  mem_pipe_if.slave bus
);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = RESP_DEPTH > 1 ? $clog2(RESP_DEPTH) : 1;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] fifo [RESP_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt, oc;
  logic [DATA_WIDTH-1:0] last;
  logic acc, rd, pop, push;
  logic [DATA_WIDTH-1:0] push_d;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(RESP_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign bus.req_ready = !rst && oc < CW'(RESP_DEPTH);
  assign acc = bus.req_valid && bus.req_ready;
  assign rd = acc && !bus.req_write;
  assign pop = bus.resp_valid && bus.resp_ready;
  assign bus.resp_valid = cnt != '0;
  assign bus.resp_rdata = bus.resp_valid ? fifo[rp] : last;
  assign bus.outstanding = oc;
  always_ff @(posedge clk)
    if (acc && bus.req_write) mem[bus.req_addr] <= bus.req_wdata;
  generate
    if (READ_LATENCY == 1) begin : g_direct
      assign push = rd;
      assign push_d = mem[bus.req_addr];
    end else begin : g_pipe
      logic [READ_LATENCY-2:0] pv;
      logic [DATA_WIDTH-1:0] pd [READ_LATENCY-1];
      always_ff @(posedge clk) begin
        pv[0] <= !rst && rd;
        pd[0] <= mem[bus.req_addr];
        for (int i = 1; i < READ_LATENCY - 1; i++) begin
          pv[i] <= !rst && pv[i-1];
          pd[i] <= pd[i-1];
        end
      end
      assign push = pv[READ_LATENCY-2];
      assign push_d = pd[READ_LATENCY-2];
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (push) fifo[wp] <= push_d;
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      oc <= '0;
      last <= '0;
    end else begin
      wp <= push ? nxt(wp) : wp;
      rp <= pop ? nxt(rp) : rp;
      cnt <= cnt + CW'(push) - CW'(pop);
      oc <= oc + CW'(rd) - CW'(pop);
      if (pop) last <= fifo[rp];
    end
  end
endmodule
